lsu_mem_ctrl: RTL

Load/store initiator between the CPU execute stage and the byte-addressed data memory. It accepts one load or store request at a time using RISC-V funct3 encoding and drives the memory's rEN/wEN/addr/data interface with the team's one-hot-ish access codes. Misaligned accesses are either split into sequential byte accesses or rejected. Load results are returned with sign or zero extension and a one-cycle response strobe.

---
 rtl/lsu_mem_ctrl.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/lsu_mem_ctrl.sv
// Load/store initiator between execute stage and byte-addressed data memory.
// Aligned accesses take one memory cycle; misaligned ones are split or rejected.
module lsu_mem_ctrl #(
    parameter bit SPLIT_MISALIGNED = 1'b1,
    parameter int MEM_BYTES        = 4096
) (
    input  logic        CLK,
    input  logic        RSTn,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_load_i,
    input  logic [2:0]  req_funct3_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        resp_valid_o,
    output logic [31:0] resp_rdata_o,
    output logic        resp_err_o,
    output logic [3:0]  mem_rEN_o,
    output logic [3:0]  mem_wEN_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_SPLIT,
        S_RESP
    } state_t;

    state_t      r_state;
    state_t      w_next;

    logic        r_load;
    logic [2:0]  r_f3;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [1:0]  r_nm1;
    logic        r_err;
    logic [1:0]  r_cnt;
    logic [31:0] r_buf;
    logic [31:0] r_rdata;

    logic [2:0]  w_nm1;
    logic [32:0] w_end;
    logic        w_illegal;
    logic        w_oor;
    logic        w_mis;
    logic        w_err;
    logic        w_accept;
    logic        w_last;
    logic [31:0] w_buf_nxt;
    logic [7:0]  w_wbyte;

    // Load code for an aligned access.
    function automatic logic [3:0] rcode(input logic [2:0] f3);
        case (f3)
            3'b010:  rcode = 4'b1000;
            3'b001:  rcode = 4'b0010;
            3'b101:  rcode = 4'b1010;
            3'b000:  rcode = 4'b0001;
            3'b100:  rcode = 4'b1001;
            default: rcode = 4'b0000;
        endcase
    endfunction

    // Store code for an aligned access.
    function automatic logic [3:0] wcode(input logic [2:0] f3);
        case (f3)
            3'b010:  wcode = 4'b1000;
            3'b001:  wcode = 4'b0010;
            3'b000:  wcode = 4'b0001;
            default: wcode = 4'b0000;
        endcase
    endfunction

    // Extend assembled split-load data according to the load type.
    function automatic logic [31:0] ext(input logic [2:0] f3, input logic [31:0] b);
        case (f3)
            3'b001:  ext = {{16{b[15]}}, b[15:0]};
            3'b101:  ext = {16'h0000, b[15:0]};
            default: ext = b;
        endcase
    endfunction

    // Request decode: size, range, alignment and legality at acceptance.
    always_comb begin
        case (req_funct3_i[1:0])
            2'b00:   w_nm1 = 3'd0;
            2'b01:   w_nm1 = 3'd1;
            default: w_nm1 = 3'd3;
        endcase
        w_illegal = (req_funct3_i == 3'b011) || (req_funct3_i == 3'b110) ||
                    (req_funct3_i == 3'b111) || (!req_load_i && req_funct3_i[2]);
        w_end     = {1'b0, req_addr_i} + {30'b0, w_nm1};
        w_oor     = w_end >= 33'(MEM_BYTES);
        w_mis     = |(req_addr_i[1:0] & w_nm1[1:0]);
        w_err     = w_illegal || w_oor || (w_mis && !SPLIT_MISALIGNED);
        w_accept  = (r_state == S_IDLE) && req_valid_i;
    end

    // Split helpers: last-byte flag, merged load buffer, store byte select.
    always_comb begin
        w_last    = (r_cnt == r_nm1);
        w_buf_nxt = r_buf;
        w_wbyte   = r_wdata[7:0];
        case (r_cnt)
            2'd0: begin
                w_buf_nxt[7:0]   = mem_rdata_i[7:0];
                w_wbyte          = r_wdata[7:0];
            end
            2'd1: begin
                w_buf_nxt[15:8]  = mem_rdata_i[7:0];
                w_wbyte          = r_wdata[15:8];
            end
            2'd2: begin
                w_buf_nxt[23:16] = mem_rdata_i[7:0];
                w_wbyte          = r_wdata[23:16];
            end
            default: begin
                w_buf_nxt[31:24] = mem_rdata_i[7:0];
                w_wbyte          = r_wdata[31:24];
            end
        endcase
    end

    // State register.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (req_valid_i) begin
                    if (w_err)      w_next = S_RESP;
                    else if (w_mis) w_next = S_SPLIT;
                    else            w_next = S_ACCESS;
                end
            end
            S_ACCESS: w_next = S_RESP;
            S_SPLIT:  w_next = w_last ? S_RESP : S_SPLIT;
            default:  w_next = S_IDLE;
        endcase
    end

    // Output decode; memory strobes exist only in ACCESS and SPLIT.
    always_comb begin
        req_ready_o  = (r_state == S_IDLE);
        resp_valid_o = (r_state == S_RESP);
        resp_err_o   = (r_state == S_RESP) && r_err;
        resp_rdata_o = (r_state == S_RESP) ? r_rdata : 32'h0;
        mem_rEN_o    = 4'b0000;
        mem_wEN_o    = 4'b0000;
        mem_addr_o   = 32'h0;
        mem_wdata_o  = 32'h0;
        case (r_state)
            S_ACCESS: begin
                mem_addr_o = r_addr;
                if (r_load) begin
                    mem_rEN_o   = rcode(r_f3);
                end else begin
                    mem_wEN_o   = wcode(r_f3);
                    mem_wdata_o = r_wdata;
                end
            end
            S_SPLIT: begin
                mem_addr_o = r_addr + {30'b0, r_cnt};
                if (r_load) begin
                    mem_rEN_o   = 4'b1001;
                end else begin
                    mem_wEN_o   = 4'b0001;
                    mem_wdata_o = {24'h0, w_wbyte};
                end
            end
            default: ;
        endcase
    end

    // Latch the accepted request and its error verdict.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_load  <= 1'b0;
            r_f3    <= 3'b000;
            r_addr  <= 32'h0;
            r_wdata <= 32'h0;
            r_nm1   <= 2'd0;
            r_err   <= 1'b0;
        end else if (w_accept) begin
            r_load  <= req_load_i;
            r_f3    <= req_funct3_i;
            r_addr  <= req_addr_i;
            r_wdata <= req_wdata_i;
            r_nm1   <= w_nm1[1:0];
            r_err   <= w_err;
        end
    end

    // Byte counter and assembly buffer for split accesses.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_cnt <= 2'd0;
            r_buf <= 32'h0;
        end else if (w_accept) begin
            r_cnt <= 2'd0;
            r_buf <= 32'h0;
        end else if (r_state == S_SPLIT) begin
            r_cnt <= r_cnt + 2'd1;
            if (r_load) r_buf <= w_buf_nxt;
        end
    end

    // Load result capture; stays zero for stores and errors.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_rdata <= 32'h0;
        end else if (w_accept) begin
            r_rdata <= 32'h0;
        end else if (r_state == S_ACCESS && r_load) begin
            r_rdata <= mem_rdata_i;
        end else if (r_state == S_SPLIT && r_load && w_last) begin
            r_rdata <= ext(r_f3, w_buf_nxt);
        end
    end

endmodule
